// File: rtl/vga_timing.sv
// Free-running VGA raster timing generator: pixel/line counters, sync and blanking
// flags registered so they line up with the counters shown in the same cycle.
module vga_timing #(
    parameter int HTOTAL     = 1344,
    parameter int VTOTAL     = 806,
    parameter int HBLKSTART  = 1024,
    parameter int VBLKSTART  = 768,
    parameter int HSYNCSTART = 1048,
    parameter int HSYNCTIME  = 136,
    parameter int VSYNCSTART = 771,
    parameter int VSYNCTIME  = 6
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    output logic [10:0] hcount,
    output logic [10:0] vcount,
    output logic        hsync,
    output logic        vsync,
    output logic        hblnk,
    output logic        vblnk,
    output logic        line_start,
    output logic        frame_start,
    output logic [15:0] frame_cnt
);

    localparam logic [10:0] H_LAST = 11'(HTOTAL - 1);
    localparam logic [10:0] V_LAST = 11'(VTOTAL - 1);
    localparam logic [10:0] H_BLK  = 11'(HBLKSTART);
    localparam logic [10:0] V_BLK  = 11'(VBLKSTART);
    // Sync windows end past 2047 for large parameters, so they are compared in 12 bits.
    localparam logic [11:0] H_SYNC_BEG = 12'(HSYNCSTART);
    localparam logic [11:0] H_SYNC_END = 12'(HSYNCSTART + HSYNCTIME);
    localparam logic [11:0] V_SYNC_BEG = 12'(VSYNCSTART);
    localparam logic [11:0] V_SYNC_END = 12'(VSYNCSTART + VSYNCTIME);

    logic [10:0] h_next;
    logic [10:0] v_next;
    logic        h_wrap;
    logic        v_wrap;
    logic        line_wrap;
    logic        frame_wrap;

    always_comb begin
        h_wrap     = (hcount == H_LAST);
        v_wrap     = (vcount == V_LAST);
        line_wrap  = en && h_wrap;
        frame_wrap = line_wrap && v_wrap;
        h_next     = hcount;
        v_next     = vcount;
        if (en) begin
            h_next = h_wrap ? 11'd0 : hcount + 11'd1;
        end
        if (line_wrap) begin
            v_next = v_wrap ? 11'd0 : vcount + 11'd1;
        end
    end

    // Flags are derived from the next counter values so they match the registered counts.
    always_ff @(posedge clk) begin
        if (rst) begin
            hcount      <= 11'd0;
            vcount      <= 11'd0;
            hsync       <= 1'b0;
            vsync       <= 1'b0;
            hblnk       <= 1'b0;
            vblnk       <= 1'b0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            frame_cnt   <= 16'd0;
        end else begin
            hcount      <= h_next;
            vcount      <= v_next;
            hblnk       <= (h_next >= H_BLK);
            vblnk       <= (v_next >= V_BLK);
            hsync       <= ({1'b0, h_next} >= H_SYNC_BEG) && ({1'b0, h_next} < H_SYNC_END);
            vsync       <= ({1'b0, v_next} >= V_SYNC_BEG) && ({1'b0, v_next} < V_SYNC_END);
            line_start  <= line_wrap;
            frame_start <= frame_wrap;
            if (frame_wrap) begin
                frame_cnt <= frame_cnt + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_vga_timing.sv
// Bench for vga_timing: full-width lines with a shortened frame height, checked every
// cycle against a pixel-count model plus hand-computed literal expectations.
`timescale 1ns/1ps
module tb_vga_timing;

    localparam int HT    = 1344;
    localparam int VT    = 16;
    localparam int HBS   = 1024;
    localparam int VBS   = 11;
    localparam int HSS   = 1048;
    localparam int HST   = 136;
    localparam int VSS   = 12;
    localparam int VST   = 3;
    localparam int FRAME = HT * VT;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en  = 1'b0;
    logic [10:0] hcount;
    logic [10:0] vcount;
    logic        hsync;
    logic        vsync;
    logic        hblnk;
    logic        vblnk;
    logic        line_start;
    logic        frame_start;
    logic [15:0] frame_cnt;
    logic [43:0] act_v;

    int n_cmp  = 0;
    int n_fail = 0;
    bit check_en = 1'b0;

    // Model state: number of pixel advances since reset, and whether the last edge advanced.
    longint      adv      = 0;
    bit          adv_last = 1'b0;
    int unsigned adj      = 0;

    vga_timing #(
        .HTOTAL(HT), .VTOTAL(VT), .HBLKSTART(HBS), .VBLKSTART(VBS),
        .HSYNCSTART(HSS), .HSYNCTIME(HST), .VSYNCSTART(VSS), .VSYNCTIME(VST)
    ) dut (
        .clk(clk), .rst(rst), .en(en),
        .hcount(hcount), .vcount(vcount),
        .hsync(hsync), .vsync(vsync), .hblnk(hblnk), .vblnk(vblnk),
        .line_start(line_start), .frame_start(frame_start), .frame_cnt(frame_cnt)
    );

    always #5 clk = ~clk;

    assign act_v = {hcount, vcount, hsync, vsync, hblnk, vblnk, line_start, frame_start, frame_cnt};

    always @(posedge clk) begin
        if (rst) begin
            adv      <= 0;
            adv_last <= 1'b0;
        end else begin
            if (en) adv <= adv + 1;
            adv_last <= en;
        end
    end

    function automatic logic [43:0] model_out(longint a, bit last, int unsigned adj_v);
        longint      p;
        int          h;
        int          v;
        logic [15:0] f;
        p = a % FRAME;
        h = int'(p % HT);
        v = int'(p / HT);
        f = 16'((longint'(adj_v) + a / FRAME) % 65536);
        return {11'(h), 11'(v),
                (h >= HSS && h < HSS + HST), (v >= VSS && v < VSS + VST),
                (h >= HBS), (v >= VBS),
                (last && h == 0), (last && p == 0), f};
    endfunction

    task automatic applyStimulus(input logic rst_v, input logic en_v);
        rst = rst_v;
        en  = en_v;
    endtask

    task automatic checkOutput(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    // One clock: wait for the falling edge, then compare all outputs with the model.
    task automatic tick();
        logic [43:0] exp_v;
        @(negedge clk);
        if (check_en) begin
            exp_v = model_out(adv, adv_last, adj);
            n_cmp++;
            if (act_v !== exp_v) begin
                n_fail++;
                $display("[TB] FAIL model_cycle @%0t: got h=%0d v=%0d flags=%b fcnt=%0h, expected h=%0d v=%0d flags=%b fcnt=%0h",
                         $time, act_v[43:33], act_v[32:22], act_v[21:16], act_v[15:0],
                         exp_v[43:33], exp_v[32:22], exp_v[21:16], exp_v[15:0]);
            end
        end
    endtask

    initial begin
        #1_500_000;
        $display("[TB] FAIL timeout: simulation did not finish in time");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        int cnt_hb;
        int cnt_hs;
        int cnt_ls;
        int cnt_vs;
        int cnt_vb;
        int cnt_fs;
        longint rem;

        applyStimulus(1'b1, 1'b1);
        repeat (3) tick();
        check_en = 1'b1;
        checkOutput("reset_state", 64'(act_v), 64'd0);

        // One full line from release.
        applyStimulus(1'b0, 1'b1);
        checkOutput("release_h0", 64'(hcount), 64'd0);
        cnt_hb = 0; cnt_hs = 0; cnt_ls = 0;
        for (int i = 1; i <= HT; i++) begin
            tick();
            if (i == 1) begin
                checkOutput("first_inc_h", 64'(hcount), 64'd1);
                checkOutput("first_inc_ls", 64'(line_start), 64'd0);
            end
            cnt_hb += int'(hblnk);
            cnt_hs += int'(hsync);
            cnt_ls += int'(line_start);
        end
        checkOutput("line_hblnk_cnt", 64'(cnt_hb), 64'd320);
        checkOutput("line_hsync_cnt", 64'(cnt_hs), 64'd136);
        checkOutput("line_ls_cnt", 64'(cnt_ls), 64'd1);
        checkOutput("line_wrap_h", 64'(hcount), 64'd0);
        checkOutput("line_wrap_v", 64'(vcount), 64'd1);
        checkOutput("line_wrap_ls", 64'(line_start), 64'd1);

        // Alternate enable for two lines' worth of advances.
        cnt_ls = 0;
        for (int i = 0; i < 4 * HT; i++) begin
            applyStimulus(1'b0, (i % 2) == 0);
            tick();
            cnt_ls += int'(line_start);
        end
        checkOutput("toggle_ls_cnt", 64'(cnt_ls), 64'd2);
        checkOutput("toggle_h", 64'(hcount), 64'd0);
        checkOutput("toggle_v", 64'(vcount), 64'd3);
        checkOutput("toggle_ls_end", 64'(line_start), 64'd0);

        // Finish the first frame.
        applyStimulus(1'b0, 1'b1);
        cnt_vs = 0; cnt_vb = 0; cnt_fs = 0;
        for (int i = 0; i < FRAME - 3 * HT; i++) begin
            tick();
            cnt_vs += int'(vsync);
            cnt_vb += int'(vblnk);
            cnt_fs += int'(frame_start);
        end
        checkOutput("frame_vsync_cnt", 64'(cnt_vs), 64'(3 * 1344));
        checkOutput("frame_vblnk_cnt", 64'(cnt_vb), 64'(5 * 1344));
        checkOutput("frame_fs_cnt", 64'(cnt_fs), 64'd1);
        checkOutput("frame_wrap_hv", 64'({hcount, vcount}), 64'd0);
        checkOutput("frame_wrap_pulses", 64'({line_start, frame_start}), 64'd3);
        checkOutput("frame_cnt_one", 64'(frame_cnt), 64'd1);

        // Reset in the middle of the vsync lines.
        repeat (13 * HT + 1100) tick();
        checkOutput("pre_reset_hv", 64'({hcount, vcount}), 64'({11'd1100, 11'd13}));
        checkOutput("pre_reset_flags", 64'({hsync, vsync, hblnk, vblnk}), 64'hF);
        applyStimulus(1'b1, 1'b1);
        tick();
        checkOutput("mid_reset_state", 64'(act_v), 64'd0);
        applyStimulus(1'b1, 1'b0);
        tick();
        applyStimulus(1'b0, 1'b1);
        tick();
        checkOutput("post_reset_h", 64'(hcount), 64'd1);
        checkOutput("post_reset_pulses", 64'({line_start, frame_start}), 64'd0);
        repeat (4) tick();

        // Preload the frame counter just below its wrap point.
        applyStimulus(1'b0, 1'b0);
        tick();
        check_en = 1'b0;
        force dut.frame_cnt = 16'hFFFF;
        tick();
        release dut.frame_cnt;
        adj = 32'((65536 + 65535 - (adv / FRAME)) % 65536);
        check_en = 1'b1;
        checkOutput("preload_fcnt", 64'(frame_cnt), 64'hFFFF);
        applyStimulus(1'b0, 1'b1);
        rem = FRAME - adv;
        for (longint i = 1; i < rem; i++) tick();
        checkOutput("pre_wrap_fcnt", 64'(frame_cnt), 64'hFFFF);
        tick();
        checkOutput("wrap_fcnt", 64'(frame_cnt), 64'd0);
        checkOutput("wrap_pulses", 64'({line_start, frame_start}), 64'd3);
        checkOutput("wrap_hv_flags", 64'({hcount, vcount, hsync, vsync, hblnk, vblnk}), 64'd0);
        repeat (3) tick();
        checkOutput("wrap_fs_clear", 64'(frame_start), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/vga_timing.md
VGA_TIMING -- requirements
Module: vga_timing

Interface
REQ-001 Parameter HTOTAL, default 1344, total clock periods per line.
REQ-002 Parameter VTOTAL, default 806, total lines per frame.
REQ-003 Parameter HBLKSTART, default 1024, first blanked hcount.
REQ-004 Parameter VBLKSTART, default 768, first blanked vcount.
REQ-005 Parameter HSYNCSTART, default 1048, first hsync hcount.
REQ-006 Parameter HSYNCTIME, default 136, hsync length in clocks.
REQ-007 Parameter VSYNCSTART, default 771, first vsync line.
REQ-008 Parameter VSYNCTIME, default 6, vsync length in lines.
REQ-009 clk  in  1  single system clock (65 MHz pixel clock); all logic on the rising edge.
REQ-010 rst  in  1  synchronous, active-high reset.
REQ-011 en  in  1  pixel advance enable; counters step only when high.
REQ-012 hcount  out  11  current pixel column, 0..HTOTAL-1.
REQ-013 vcount  out  11  current line, 0..VTOTAL-1.
REQ-014 hsync  out  1  active-high horizontal sync.
REQ-015 vsync  out  1  active-high vertical sync.
REQ-016 hblnk  out  1  horizontal blanking.
REQ-017 vblnk  out  1  vertical blanking.
REQ-018 line_start  out  1  one-clock pulse at hcount wrap to 0.
REQ-019 frame_start  out  1  one-clock pulse at (hcount,vcount) wrap to (0,0).
REQ-020 frame_cnt  out  16  completed-frame counter, wraps modulo 2^16.

Function
REQ-021 All outputs SHALL be registered; hsync/vsync/hblnk/vblnk SHALL be computed from the next-state counter values, so each flag is consistent with the hcount/vcount shown in the same cycle (zero relative latency).
REQ-022 With en=1, hcount SHALL increment by 1 per clock; at HTOTAL-1 it SHALL wrap to 0 and vcount SHALL increment.
REQ-023 When hcount wraps and vcount=VTOTAL-1, vcount SHALL wrap to 0 and frame_cnt SHALL increment by 1 in the same cycle.
REQ-024 With en=0, hcount, vcount, hsync, vsync, hblnk, vblnk and frame_cnt SHALL hold.
REQ-025 hblnk SHALL be 1 iff hcount >= HBLKSTART (1024..1343 by default).
REQ-026 vblnk SHALL be 1 iff vcount >= VBLKSTART (768..805).
REQ-027 hsync SHALL be 1 iff HSYNCSTART <= hcount < HSYNCSTART+HSYNCTIME (1048..1183).
REQ-028 vsync SHALL be 1 iff VSYNCSTART <= vcount < VSYNCSTART+VSYNCTIME (771..776), across the full line including hblnk.
REQ-029 line_start SHALL be 1 for exactly one clock, in the cycle hcount first shows 0 after a wrap; 0 in all other cycles, including while en=0.
REQ-030 frame_start SHALL be 1 for exactly one clock, in the cycle (hcount,vcount) first shows (0,0) after a frame wrap; line_start SHALL also be 1 in that cycle.
REQ-031 All comparisons SHALL be unsigned 11-bit; counters SHALL never reach HTOTAL or VTOTAL.
REQ-032 Counter widths SHALL be 11 bits; parameter values up to 2047 SHALL be supported without change.

Reset
REQ-033 While rst=1 at a clock edge: hcount=0, vcount=0, frame_cnt=0, all of hsync, vsync, hblnk, vblnk, line_start, frame_start = 0, regardless of en.
REQ-034 Reset mid-line or mid-frame SHALL take effect on the next edge; the first cycle after release SHALL show (0,0) with no line_start/frame_start pulse.
REQ-035 After reset release with en=1, the first increment SHALL give hcount=1 on the second edge.

Verification
REQ-036 Reset, en=1 for 1344 clocks -> hcount 0..1343 then 0, vcount 0->1, line_start=1 exactly once at the wrap cycle.
REQ-037 Run one full line -> hblnk high exactly 320 clocks (1024..1343), hsync high exactly 136 clocks (1048..1183), both aligned with hcount.
REQ-038 Run 1344*806 clocks -> vsync high for lines 771..776 (6*1344 clocks), vblnk high lines 768..805, frame_start single pulse at (0,0), frame_cnt=1.
REQ-039 Toggle en 1/0 alternately for two lines -> counts advance only on en=1 cycles, outputs hold otherwise, line_start pulses last one clock even with en=0 next.
REQ-040 Assert rst at (hcount=1100, vcount=772) -> next edge all outputs 0, counts (0,0), frame_cnt=0, no pulse after release.
REQ-041 Preload frame_cnt near 65535 by running frames (or force) -> wraps to 0 at next frame_start, no other output disturbed.
